sb_ram_slave: RTL and testbench
===============================

Name: sb_ram_slave

Overview:
- System-bus responder (slave end) for the sb_* read/write channel protocol driven by the core's instruction-fetch and load/store masters.
- Backs a word-organised on-chip RAM with independent read and write channel FSMs and programmable wait states.
- Returns rdata on the read channel and a 1-bit bresp on the write channel.
- Sits behind the bus interconnect as a memory target, e.g. the data/instruction RAM.

Parameters:
ADDR_BASE, 32'h2000_0000, byte base address of the RAM window (4 KB aligned)
DEPTH_WORDS, 1024, number of 32-bit words; power of two
RD_WAIT, 0, extra cycles between AR handshake and rvalid (0..15)
WR_WAIT, 0, extra cycles between W handshake and commit/bvalid (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sb_arvalid  in  1  read address valid
sb_arready  out  1  read address ready
sb_araddr  in  32  read byte address
sb_rvalid  out  1  read data valid
sb_rready  in  1  read data ready
sb_rdata  out  32  read data
sb_wvalid  in  1  write valid (address, data and strobe together)
sb_wready  out  1  write ready
sb_waddr  in  32  write byte address
sb_wdata  in  32  write data
sb_wstrb  in  4  byte strobes; bit i enables byte lane i
sb_bvalid  out  1  write response valid
sb_bready  in  1  write response ready
sb_bresp  out  1  0 = OKAY, 1 = error (address out of window)

Behaviour:
- Reset values: sb_arready=0, sb_wready=0, sb_rvalid=0, sb_bvalid=0, sb_rdata=0, sb_bresp=0, both FSMs in IDLE.
- RAM contents are not reset.
- Ready flags are registered; both go to 1 on the first clk edge after rst_n deasserts.
- Handshake on a channel = valid & ready at a clk edge. A master must hold valid and payload until the handshake.
- Word indexing: addr[1:0] ignored; word index = (addr - ADDR_BASE) >> 2.
- In-window test: ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS, evaluated at handshake.
- Read FSM states: IDLE, WAIT, RESP.
  - IDLE: arready=1. On AR handshake, latch address, drop arready, go to WAIT (RD_WAIT>0) or sample immediately (RD_WAIT=0).
  - WAIT: count down RD_WAIT cycles, then sample RAM.
  - Sample: rdata <= RAM[idx] if in window, else 32'h0000_0000. Set rvalid, go to RESP. rvalid rises RD_WAIT+1 cycles after the AR handshake.
  - RESP: hold rvalid and rdata until rready. On R handshake, clear rvalid, set arready, go to IDLE.
  - Back-to-back reads: one transaction every RD_WAIT+3 cycles minimum; one outstanding read only.
- Write FSM states: IDLE, WAIT, RESP, mirroring the read FSM.
  - Commit occurs WR_WAIT cycles after the W handshake.
  - In window: for each i with wstrb[i]=1, RAM[idx][8i+7:8i] <= wdata[8i+7:8i]; bresp=0.
  - Out of window: no RAM write; bresp=1.
  - wstrb=4'b0000 in window: no byte changes, bresp=0.
  - bvalid rises on the cycle after commit and holds until bready. The B handshake re-arms wready.
- Read and write channels run fully independently and may complete handshakes in the same cycle.
- Same-cycle read sample and write commit to the same word: the read returns pre-write data (read-first), unless SB_RAM_WR_FWD_EN.
- rst_n assertion mid-transaction: immediate return to IDLE, outputs to reset values. The in-flight write is dropped if not yet committed.

Optional Feature:
- Macro: SB_RAM_WR_FWD_EN
- Defined: on a same-cycle, same-word read sample and write commit, rdata returns the byte-merged new word (strobed lanes from wdata, other lanes from RAM).
- Undefined: read-first; the old word is returned. No other behaviour differs.

Test Plan:
1. Reset, RD_WAIT=0. Write 32'hA5A5_1234 to ADDR_BASE+8, wstrb=4'hF; then read ADDR_BASE+8 -> bvalid 1 cycle after W handshake with bresp=0; rvalid 1 cycle after AR handshake with rdata=32'hA5A5_1234.
2. Byte strobes: word at ADDR_BASE+0 = 32'h1122_3344; write 32'hFFFF_FFFF with wstrb=4'b0101 -> read returns 32'h11FF_33FF.
3. Out of window: write to ADDR_BASE+4*DEPTH_WORDS -> bresp=1, RAM unchanged; read of the same address -> rdata=32'h0.
4. RD_WAIT=3, WR_WAIT=2, rready/bready held low 5 cycles -> rvalid at handshake+4, bvalid at handshake+3; rvalid/rdata and bvalid/bresp stable until ready; arready/wready stay 0 until the response handshake.
5. Collision: word = 32'h0, write 32'hDEAD_BEEF and read the same word timed so sample and commit coincide -> rdata=32'h0 without the macro, 32'hDEAD_BEEF with SB_RAM_WR_FWD_EN.
6. rst_n pulsed low during read WAIT -> rvalid=0, arready=0 during reset; arready=1 one cycle after release; a new read completes normally.

Source files
------------

// File: rtl/sb_ram_slave.sv
// rtl/sb_ram_slave.sv - sb_* bus RAM responder with independent read/write FSMs and wait states.
// Define SB_RAM_WR_FWD_EN to forward a same-cycle, same-word write commit into the read data.
module sb_ram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_WAIT     = 0,
  parameter int          WR_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sb_arvalid,
  output logic        sb_arready,
  input  logic [31:0] sb_araddr,
  output logic        sb_rvalid,
  input  logic        sb_rready,
  output logic [31:0] sb_rdata,
  input  logic        sb_wvalid,
  output logic        sb_wready,
  input  logic [31:0] sb_waddr,
  input  logic [31:0] sb_wdata,
  input  logic [3:0]  sb_wstrb,
  output logic        sb_bvalid,
  input  logic        sb_bready,
  output logic        sb_bresp
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RD_CNT    = 4'(RD_WAIT);
  localparam logic [3:0]  WR_CNT    = 4'(WR_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e             rd_state_q, rd_state_d;
  logic [3:0]         rd_cnt_q, rd_cnt_d;
  logic               rd_hit_q, rd_hit_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;

  state_e             wr_state_q, wr_state_d;
  logic [3:0]         wr_cnt_q, wr_cnt_d;
  logic               wr_hit_q, wr_hit_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [3:0]         wr_strb_q, wr_strb_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic               bresp_q, bresp_d;

  logic [31:0]        ar_off, aw_off;
  logic               ar_hit, aw_hit;
  logic [31:0]        wr_old, wr_merged, rd_word;
  logic               wr_commit;

  // The subtraction wraps for addresses below the base, so the lower bound is checked separately.
  always_comb begin
    ar_off = sb_araddr - ADDR_BASE;
    aw_off = sb_waddr - ADDR_BASE;
    ar_hit = (sb_araddr >= ADDR_BASE) && ({1'b0, ar_off} < WIN_BYTES);
    aw_hit = (sb_waddr >= ADDR_BASE) && ({1'b0, aw_off} < WIN_BYTES);
  end

  always_comb begin
    wr_old    = mem[wr_idx_q];
    wr_merged = wr_old;
    for (int i = 0; i < 4; i++) begin
      if (wr_strb_q[i]) begin
        wr_merged[8*i +: 8] = wr_data_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_idx_q];
`ifdef SB_RAM_WR_FWD_EN
    if (wr_commit && (wr_idx_q == rd_idx_q)) begin
      rd_word = wr_merged;
    end
`else
`endif
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_hit_d   = rd_hit_q;
    rd_idx_d   = rd_idx_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      ST_IDLE: begin
        if (sb_arvalid && arready_q) begin
          rd_hit_d   = ar_hit;
          rd_idx_d   = ar_off[IDX_W+1:2];
          rd_cnt_d   = RD_CNT;
          rd_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rdata_d    = rd_hit_q ? rd_word : 32'h0000_0000;
          rvalid_d   = 1'b1;
          rd_state_d = ST_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (sb_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = ST_IDLE;
        end
      end
      default: rd_state_d = ST_IDLE;
    endcase
    arready_d = (rd_state_d == ST_IDLE);
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_hit_d   = wr_hit_q;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      ST_IDLE: begin
        if (sb_wvalid && wready_q) begin
          wr_hit_d   = aw_hit;
          wr_idx_d   = aw_off[IDX_W+1:2];
          wr_data_d  = sb_wdata;
          wr_strb_d  = sb_wstrb;
          wr_cnt_d   = WR_CNT;
          wr_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          wr_commit  = wr_hit_q;
          bresp_d    = ~wr_hit_q;
          bvalid_d   = 1'b1;
          wr_state_d = ST_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (sb_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = ST_IDLE;
        end
      end
      default: wr_state_d = ST_IDLE;
    endcase
    wready_d = (wr_state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= ST_IDLE;
      rd_cnt_q   <= 4'd0;
      rd_hit_q   <= 1'b0;
      rd_idx_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_hit_q   <= rd_hit_d;
      rd_idx_q   <= rd_idx_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= ST_IDLE;
      wr_cnt_q   <= 4'd0;
      wr_hit_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= 32'h0000_0000;
      wr_strb_q  <= 4'h0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_hit_q   <= wr_hit_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Storage is not reset; a reset during WAIT leaves wr_commit low, dropping the write.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_idx_q] <= wr_merged;
    end
  end

  assign sb_arready = arready_q;
  assign sb_rvalid  = rvalid_q;
  assign sb_rdata   = rdata_q;
  assign sb_wready  = wready_q;
  assign sb_bvalid  = bvalid_q;
  assign sb_bresp   = bresp_q;

endmodule

// File: tb/tb_sb_ram_slave.sv
// tb/tb_sb_ram_slave.sv - directed bench for sb_ram_slave with zero-wait and wait-state instances.
module tb_sb_ram_slave;

  localparam logic [31:0] B    = 32'h2000_0000;
  localparam int          RDW1 = 3;
  localparam int          WRW1 = 2;
  localparam int          NV   = 20;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_bresp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        rst_n   [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [31:0] waddr   [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic        bresp   [2];

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs [NV];

  sb_ram_slave #(.ADDR_BASE(B), .DEPTH_WORDS(1024), .RD_WAIT(0), .WR_WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .sb_arvalid(arvalid[0]), .sb_arready(arready[0]), .sb_araddr(araddr[0]),
    .sb_rvalid(rvalid[0]), .sb_rready(rready[0]), .sb_rdata(rdata[0]),
    .sb_wvalid(wvalid[0]), .sb_wready(wready[0]), .sb_waddr(waddr[0]),
    .sb_wdata(wdata[0]), .sb_wstrb(wstrb[0]),
    .sb_bvalid(bvalid[0]), .sb_bready(bready[0]), .sb_bresp(bresp[0])
  );

  sb_ram_slave #(.ADDR_BASE(B), .DEPTH_WORDS(1024), .RD_WAIT(RDW1), .WR_WAIT(WRW1)) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .sb_arvalid(arvalid[1]), .sb_arready(arready[1]), .sb_araddr(araddr[1]),
    .sb_rvalid(rvalid[1]), .sb_rready(rready[1]), .sb_rdata(rdata[1]),
    .sb_wvalid(wvalid[1]), .sb_wready(wready[1]), .sb_waddr(waddr[1]),
    .sb_wdata(wdata[1]), .sb_wstrb(wstrb[1]),
    .sb_bvalid(bvalid[1]), .sb_bready(bready[1]), .sb_bresp(bresp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic int lat_r(input int d);
    return (d == 0) ? 1 : RDW1 + 1;
  endfunction

  function automatic int lat_w(input int d);
    return (d == 0) ? 1 : WRW1 + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_wr(input int d, input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] s, input logic eb, input string nm);
    int n;
    int k;
    @(negedge clk);
    wvalid[d] = 1'b1; waddr[d] = a; wdata[d] = dat; wstrb[d] = s; bready[d] = 1'b1;
    n = 0;
    while (wready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_wready"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    wvalid[d] = 1'b0;
    k = 0;
    while (bvalid[d] !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    chk({nm, "_blat"}, 32'(k), 32'(lat_w(d)));
    chk({nm, "_bresp"}, 32'(bresp[d]), 32'(eb));
    @(negedge clk);
    chk({nm, "_bdone"}, {30'd0, bvalid[d], wready[d]}, 32'd1);
    bready[d] = 1'b0;
  endtask

  task automatic do_rd(input int d, input logic [31:0] a, input logic [31:0] exp, input string nm);
    int n;
    int k;
    @(negedge clk);
    arvalid[d] = 1'b1; araddr[d] = a; rready[d] = 1'b1;
    n = 0;
    while (arready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_arready"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    arvalid[d] = 1'b0;
    k = 0;
    while (rvalid[d] !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    chk({nm, "_rlat"}, 32'(k), 32'(lat_r(d)));
    chk({nm, "_rdata"}, rdata[d], exp);
    @(negedge clk);
    chk({nm, "_rdone"}, {30'd0, rvalid[d], arready[d]}, 32'd1);
    rready[d] = 1'b0;
  endtask

  // Read and write handshake on the same edge, so sample and commit coincide one edge later.
  task automatic collide(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                         input logic [31:0] exp, input string nm);
    @(negedge clk);
    arvalid[0] = 1'b1; araddr[0] = a; rready[0] = 1'b1;
    wvalid[0] = 1'b1; waddr[0] = a; wdata[0] = dat; wstrb[0] = s; bready[0] = 1'b1;
    chk({nm, "_rdy"}, {30'd0, arready[0], wready[0]}, 32'd3);
    @(negedge clk);
    arvalid[0] = 1'b0; wvalid[0] = 1'b0;
    chk({nm, "_early"}, {30'd0, rvalid[0], bvalid[0]}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {30'd0, rvalid[0], bvalid[0]}, 32'd3);
    chk({nm, "_rdata"}, rdata[0], exp);
    @(negedge clk);
    chk({nm, "_done"}, {30'd0, rvalid[0], bvalid[0]}, 32'd0);
    rready[0] = 1'b0; bready[0] = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_c1;
    logic [31:0] exp_c2;
`ifdef SB_RAM_WR_FWD_EN
    exp_c1 = 32'hDEAD_BEEF;
    exp_c2 = 32'h1122_CCDD;
`else
    exp_c1 = 32'h0000_0000;
    exp_c2 = 32'h1122_3344;
`endif
    vecs[0]  = '{1'b1, B + 32'd8,    32'hA5A5_1234, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, B + 32'd8,    32'h0,         4'h0, 1'b0, 32'hA5A5_1234};
    vecs[2]  = '{1'b1, B,            32'h1122_3344, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, B,            32'hFFFF_FFFF, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, B,            32'h0,         4'h0, 1'b0, 32'h11FF_33FF};
    vecs[5]  = '{1'b1, B + 32'd4096, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, B + 32'd4096, 32'h0,         4'h0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, B,            32'h0,         4'h0, 1'b0, 32'h11FF_33FF};
    vecs[8]  = '{1'b1, B - 32'd4,    32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, B - 32'd4,    32'h0,         4'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, B + 32'd4092, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, B + 32'd4092, 32'h0,         4'h0, 1'b0, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, B + 32'd8,    32'h1234_5678, 4'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, B + 32'd9,    32'h0,         4'h0, 1'b0, 32'hA5A5_1234};
    vecs[14] = '{1'b1, B,            32'hAB00_CD00, 4'hA, 1'b0, 32'h0};
    vecs[15] = '{1'b0, B + 32'd3,    32'h0,         4'h0, 1'b0, 32'hABFF_CDFF};
    vecs[16] = '{1'b1, B + 32'd4095, 32'h5566_7788, 4'hF, 1'b0, 32'h0};
    vecs[17] = '{1'b0, B + 32'd4092, 32'h0,         4'h0, 1'b0, 32'h5566_7788};
    vecs[18] = '{1'b1, B + 32'd16,   32'h0000_0000, 4'hF, 1'b0, 32'h0};
    vecs[19] = '{1'b1, B + 32'd20,   32'h1122_3344, 4'hF, 1'b0, 32'h0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; arvalid[d] = 1'b0; araddr[d] = 32'h0; rready[d] = 1'b0;
      wvalid[d] = 1'b0; waddr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0; bready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", {30'd0, arready[0], wready[0]}, 32'd0);
    chk("reset_valid", {30'd0, rvalid[0], bvalid[0]}, 32'd0);
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_bresp", 32'(bresp[0]), 32'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk("release_ready", {30'd0, arready[0], wready[0]}, 32'd3);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr)
        do_wr(0, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_bresp, $sformatf("vec%0d", i));
      else
        do_rd(0, vecs[i].addr, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end

    collide(B + 32'd16, 32'hDEAD_BEEF, 4'hF, exp_c1, "coll_full");
    do_rd(0, B + 32'd16, 32'hDEAD_BEEF, "coll_full_after");
    collide(B + 32'd20, 32'hAABB_CCDD, 4'h3, exp_c2, "coll_part");
    do_rd(0, B + 32'd20, 32'h1122_CCDD, "coll_part_after");

    // Wait-state instance: responses held off by the master.
    @(negedge clk);
    wvalid[1] = 1'b1; waddr[1] = B + 32'd12; wdata[1] = 32'h0BAD_F00D; wstrb[1] = 4'hF; bready[1] = 1'b0;
    chk("ws_w_rdy", 32'(wready[1]), 32'd1);
    @(negedge clk);
    wvalid[1] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("ws_bvalid_k%0d", k), 32'(bvalid[1]), 32'(k >= WRW1 + 1));
      chk($sformatf("ws_wready_k%0d", k), 32'(wready[1]), 32'd0);
      if (k >= WRW1 + 1) chk($sformatf("ws_bresp_k%0d", k), 32'(bresp[1]), 32'd0);
      if (k < 8) @(negedge clk);
    end
    bready[1] = 1'b1;
    @(negedge clk);
    chk("ws_b_done", {30'd0, bvalid[1], wready[1]}, 32'd1);
    bready[1] = 1'b0;

    arvalid[1] = 1'b1; araddr[1] = B + 32'd12; rready[1] = 1'b0;
    chk("ws_ar_rdy", 32'(arready[1]), 32'd1);
    @(negedge clk);
    arvalid[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("ws_rvalid_k%0d", k), 32'(rvalid[1]), 32'(k >= RDW1 + 1));
      chk($sformatf("ws_arready_k%0d", k), 32'(arready[1]), 32'd0);
      if (k >= RDW1 + 1) chk($sformatf("ws_rdata_k%0d", k), rdata[1], 32'h0BAD_F00D);
      if (k < 9) @(negedge clk);
    end
    rready[1] = 1'b1;
    @(negedge clk);
    chk("ws_r_done", {30'd0, rvalid[1], arready[1]}, 32'd1);
    rready[1] = 1'b0;

    // Reset while both channels sit in WAIT; the pending write must not land.
    @(negedge clk);
    arvalid[1] = 1'b1; araddr[1] = B + 32'd12;
    wvalid[1] = 1'b1; waddr[1] = B + 32'd12; wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'hF;
    @(negedge clk);
    arvalid[1] = 1'b0; wvalid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_valid", {30'd0, rvalid[1], bvalid[1]}, 32'd0);
    chk("rst_mid_ready", {30'd0, arready[1], wready[1]}, 32'd0);
    @(negedge clk);
    chk("rst_hold_ready", {30'd0, arready[1], wready[1]}, 32'd0);
    chk("rst_hold_rvalid", 32'(rvalid[1]), 32'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", {30'd0, arready[1], wready[1]}, 32'd3);
    do_rd(1, B + 32'd12, 32'h0BAD_F00D, "rst_after");
    do_wr(1, B + 32'd4096, 32'h1, 4'hF, 1'b1, "ws_oow");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
